// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int          PC_INC    = 4;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous {instr, pc} FIFO with push, pop, flush and occupancy count.
// Head outputs read registered storage only and show NOP/0 when empty.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [31:0]            instr_i,
    input  logic [AW-1:0]          pc_i,
    output logic                   head_valid_o,
    output logic [31:0]            head_instr_o,
    output logic [AW-1:0]          head_pc_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] pc_mem    [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_ff @(negedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; validity comes from count_q alone.
    always_ff @(negedge clk_i) begin
        if (push_i) begin
            instr_mem[wr_ptr_q] <= instr_i;
            pc_mem[wr_ptr_q]    <= pc_i;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_instr_o = head_valid_o ? instr_mem[rd_ptr_q] : NOP_INSTR;
    assign head_pc_o    = head_valid_o ? pc_mem[rd_ptr_q] : '0;
    assign count_o      = count_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Sequential instruction prefetcher: one outstanding req/ack fetch, a small
// instruction FIFO toward IF/ID, and branch redirect with in-flight squash.
module instr_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [AW-1:0]          startPC,
    input  logic                   redirect,
    input  logic [AW-1:0]          redirectPC,
    output logic                   imemReq,
    output logic [AW-1:0]          imemAddr,
    input  logic                   imemAck,
    input  logic [31:0]            imemData,
    input  logic                   instrTake,
    output logic                   instrValid,
    output logic [31:0]            instr,
    output logic [AW-1:0]          instrPC,
    output logic [AW-1:0]          instrPCPlus4,
    output logic [$clog2(DEPTH):0] count
);
    localparam int            CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] imem_addr_q, imem_addr_d;
    logic [AW-1:0] seq_pc;
    logic [CW-1:0] count_next;
    logic          push, pop, flush;

    assign pop    = instrTake && instrValid;
    assign seq_pc = fetch_pc_q + AW'(PC_INC);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        imem_addr_d = imem_addr_q;
        push        = 1'b0;
        flush       = 1'b0;
        // NOTE: blocking assignments here; count_next is refined in place once a push is known.
        count_next  = count - CW'(pop);
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    flush       = 1'b1;
                    fetch_pc_d  = redirectPC;
                    imem_addr_d = redirectPC;
                    state_d     = REQ;
                end else if (count_next < FULL_COUNT) begin
                    imem_addr_d = fetch_pc_q;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirectPC;
                    if (imemAck) imem_addr_d = redirectPC;
                    else         state_d     = SQUASH;
                end else if (imemAck) begin
                    push       = 1'b1;
                    count_next = count_next + CW'(1);
                    fetch_pc_d = seq_pc;
                    if (count_next < FULL_COUNT) imem_addr_d = seq_pc;
                    else                         state_d     = IDLE;
                end
            end
            SQUASH: begin
                // The stale request must finish before the redirected fetch can issue.
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirectPC;
                end
                if (imemAck) begin
                    imem_addr_d = redirect ? redirectPC : fetch_pc_q;
                    state_d     = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge CLK) begin
        if (Reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= startPC;
            imem_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    assign imemReq  = (state_q != IDLE);
    assign imemAddr = imem_addr_q;

    instr_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i        (CLK),
        .rst_i        (Reset),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (flush),
        .instr_i      (imemData),
        .pc_i         (imem_addr_q),
        .head_valid_o (instrValid),
        .head_instr_o (instr),
        .head_pc_o    (instrPC),
        .count_o      (count)
    );

    assign instrPCPlus4 = instrValid ? instrPC + AW'(PC_INC) : '0;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Scoreboard bench for instr_prefetch_unit: directed scenarios push expected
// PCs, a memory model answers fetches, and a monitor checks every consumed entry.
module tb_instr_prefetch_unit;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic                   CLK, Reset, redirect, imemAck, instrTake;
    logic                   imemReq, instrValid;
    logic [AW-1:0]          startPC, redirectPC, imemAddr, instrPC, instrPCPlus4;
    logic [31:0]            imemData, instr;
    logic [$clog2(DEPTH):0] count;

    int          n_vec     = 0;
    int          n_err     = 0;
    int          mem_waits = 0;
    int          wait_cnt  = 0;
    int          ack_cnt   = 0;
    logic [31:0] exp_q[$];

    instr_prefetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .startPC      (startPC),
        .redirect     (redirect),
        .redirectPC   (redirectPC),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemAck      (imemAck),
        .imemData     (imemData),
        .instrTake    (instrTake),
        .instrValid   (instrValid),
        .instr        (instr),
        .instrPC      (instrPC),
        .instrPCPlus4 (instrPCPlus4),
        .count        (count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_F00D;
    endfunction

    // DUT state changes on the falling edge; the bench works on the rising edge:
    // +1 memory decides ack, +2 stimulus drives and checks, +3 monitor samples.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back(pc);
    endtask

    task automatic drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset(input logic [31:0] pc);
        instrTake = 1'b0;
        redirect  = 1'b0;
        Reset     = 1'b1;
        startPC   = pc;
        tick();
        check("rst_imemReq",  32'(imemReq), 32'd0);
        check("rst_imemAddr", imemAddr, 32'd0);
        check("rst_valid",    32'(instrValid), 32'd0);
        check("rst_instr",    instr, 32'd0);
        check("rst_pc",       instrPC, 32'd0);
        check("rst_pc4",      instrPCPlus4, 32'd0);
        check("rst_count",    32'(count), 32'd0);
        Reset = 1'b0;
        exp_q.delete();
        ack_cnt = 0;
    endtask

    task automatic wait_ack(input string name, input int budget);
        int n = 0;
        while (imemAck !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(imemAck), 32'd1);
    endtask

    // Instruction memory with a programmable number of wait cycles.
    initial begin
        imemAck  = 1'b0;
        imemData = 32'h0;
        forever begin
            @(posedge CLK);
            #1;
            if (imemReq === 1'b1) begin
                if (wait_cnt >= mem_waits) begin
                    imemAck  = 1'b1;
                    imemData = mem_word(imemAddr);
                    ack_cnt++;
                    wait_cnt = 0;
                end else begin
                    imemAck  = 1'b0;
                    imemData = 32'h0;
                    wait_cnt++;
                end
            end else begin
                imemAck  = 1'b0;
                imemData = 32'h0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every entry decode actually consumes must match the scoreboard head.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge CLK);
            #3;
            if (instrValid === 1'b1 && instrTake === 1'b1 && redirect !== 1'b1 && Reset !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_entry: got pc %h, expected none (t=%0t)", instrPC, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_pc",    instrPC, e);
                    check("mon_instr", instr, mem_word(e));
                    check("mon_pc4",   instrPCPlus4, e + 32'd4);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] wrap_pcs [3];
        wrap_pcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        Reset      = 1'b1;
        startPC    = '0;
        redirect   = 1'b0;
        redirectPC = '0;
        instrTake  = 1'b0;
        tick();

        // Zero-wait streaming from 0x00400000, one instruction per cycle.
        mem_waits = 0;
        apply_reset(32'h0040_0000);
        instrTake = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("s1_addr", imemAddr, 32'h0040_0000 + 32'(4 * i));
            if (i > 0) check("s1_valid", 32'(instrValid), 32'd1);
            push_exp(32'h0040_0000 + 32'(4 * i));
            tick();
        end
        tick();
        instrTake = 1'b0;
        drained("s1_drained");

        // Decode stalled: FIFO fills to DEPTH, then one take refetches one PC.
        apply_reset(32'h0040_0000);
        for (int i = 0; i < 6; i++) tick();
        check("s2_req_idle", 32'(imemReq), 32'd0);
        check("s2_count4",   32'(count), 32'd4);
        check("s2_acks4",    32'(ack_cnt), 32'd4);
        check("s2_head_pc",  instrPC, 32'h0040_0000);
        push_exp(32'h0040_0000);
        instrTake = 1'b1;
        tick();
        instrTake = 1'b0;
        check("s2_req_again", 32'(imemReq), 32'd1);
        check("s2_next_addr", imemAddr, 32'h0040_0010);
        check("s2_count3",    32'(count), 32'd3);
        tick();
        check("s2_refull",    32'(count), 32'd4);
        check("s2_req_off",   32'(imemReq), 32'd0);
        check("s2_acks5",     32'(ack_cnt), 32'd5);
        check("s2_head_pc2",  instrPC, 32'h0040_0004);
        drained("s2_drained");

        // 3-wait memory, redirect while a request is outstanding.
        mem_waits = 3;
        apply_reset(32'h0040_0000);
        instrTake = 1'b1;
        tick();
        push_exp(32'h0040_0000);
        wait_ack("s3_first_ack", 10);
        tick();
        tick();
        redirect   = 1'b1;
        redirectPC = 32'h0040_0100;
        check("s3_addr_at_redirect", imemAddr, 32'h0040_0004);
        tick();
        redirect = 1'b0;
        for (int n = 0; n < 10; n++) begin
            check("s3_addr_held", imemAddr, 32'h0040_0004);
            check("s3_req_held",  32'(imemReq), 32'd1);
            check("s3_count0",    32'(count), 32'd0);
            if (imemAck === 1'b1) break;
            tick();
        end
        tick();
        check("s3_new_addr",  imemAddr, 32'h0040_0100);
        check("s3_discarded", 32'(count), 32'd0);
        check("s3_no_valid",  32'(instrValid), 32'd0);
        push_exp(32'h0040_0100);
        wait_ack("s3_second_ack", 10);
        tick();
        check("s3_head_pc", instrPC, 32'h0040_0100);
        tick();
        instrTake = 1'b0;
        drained("s3_drained");

        // Redirect, ack and take in the same cycle: flush wins.
        mem_waits = 0;
        apply_reset(32'h0040_0000);
        tick();
        tick();
        tick();
        check("s4_count2", 32'(count), 32'd2);
        redirect   = 1'b1;
        redirectPC = 32'h0040_0200;
        instrTake  = 1'b1;
        tick();
        redirect  = 1'b0;
        instrTake = 1'b0;
        check("s4_count0", 32'(count), 32'd0);
        check("s4_empty",  32'(instrValid), 32'd0);
        check("s4_nop",    instr, 32'd0);
        check("s4_addr",   imemAddr, 32'h0040_0200);
        check("s4_req",    32'(imemReq), 32'd1);
        tick();
        check("s4_count1", 32'(count), 32'd1);
        check("s4_pc4",    instrPCPlus4, 32'h0040_0204);
        push_exp(32'h0040_0200);
        instrTake = 1'b1;
        tick();
        instrTake = 1'b0;
        drained("s4_drained");

        // PC wrap-around from the top of the address space.
        apply_reset(32'hFFFF_FFF8);
        instrTake = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("s5_addr", imemAddr, wrap_pcs[i]);
            push_exp(wrap_pcs[i]);
            tick();
        end
        check("s5_last_pc",  instrPC, 32'h0000_0000);
        check("s5_last_pc4", instrPCPlus4, 32'h0000_0004);
        tick();
        instrTake = 1'b0;
        drained("s5_drained");

        // Reset mid-request with the ack landing in the reset cycle.
        mem_waits = 3;
        apply_reset(32'h0040_0000);
        tick();
        check("s6_req", 32'(imemReq), 32'd1);
        wait_ack("s6_ack", 10);
        Reset   = 1'b1;
        startPC = 32'h0050_0000;
        tick();
        check("s6_req_off", 32'(imemReq), 32'd0);
        check("s6_addr0",   imemAddr, 32'd0);
        check("s6_count0",  32'(count), 32'd0);
        check("s6_valid0",  32'(instrValid), 32'd0);
        check("s6_instr0",  instr, 32'd0);
        check("s6_pc0",     instrPC, 32'd0);
        Reset     = 1'b0;
        instrTake = 1'b1;
        tick();
        instrTake = 1'b0;
        check("s6_new_req",   32'(imemReq), 32'd1);
        check("s6_new_addr",  imemAddr, 32'h0050_0000);
        check("s6_take_empty", 32'(count), 32'd0);
        drained("s6_drained");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_unit.md
# instr_prefetch_unit

Fetch front end that sits directly upstream of the pipelined processor's IF/ID register. It walks sequential PCs from `startPC` and fetches words from a variable-latency instruction memory through a req/ack handshake. It buffers fetched instructions with their PCs in a small FIFO and hands them to the decode stage under the hazard unit's `IFWrite` control. A taken branch or jump redirects it, which flushes the buffer and squashes any in-flight fetch.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `AW`, 32: PC/address width.

Ports:
- `CLK`  in  1  clock. All state updates on the falling edge, matching the processor pipeline registers.
- `Reset`  in  1  synchronous, active-high reset.
- `startPC`  in  AW  fetch PC loaded on reset.
- `redirect`  in  1  taken branch/jump from the pipeline; single-cycle pulse.
- `redirectPC`  in  AW  new fetch PC; valid with `redirect`.
- `imemReq`  out  1  fetch request to instruction memory.
- `imemAddr`  out  AW  word address of the outstanding request.
- `imemAck`  in  1  memory completes the request; `imemData` is valid this cycle.
- `imemData`  in  32  fetched instruction.
- `instrTake`  in  1  decode consumes the head entry (driven by `IFWrite`).
- `instrValid`  out  1  FIFO head is valid.
- `instr`  out  32  head instruction; 0 (NOP) when empty.
- `instrPC`  out  AW  head PC; 0 when empty.
- `instrPCPlus4`  out  AW  `instrPC + 4`; 0 when empty.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- State machine with three states:
  - IDLE: no outstanding request.
  - REQ: request outstanding.
  - SQUASH: request outstanding, result to be discarded.
- `imemReq` = (state ≠ IDLE).
- `imemAddr` is registered. It is loaded from `fetchPC` on every entry into REQ and held stable until ack.
- At most one request is outstanding. The memory may ack in the same cycle that `imemReq` first rises (zero-wait).
- IDLE → REQ when `count_next < DEPTH` and no redirect. `count_next` includes this cycle's pop.
- REQ, no ack, no redirect: stay in REQ.
- REQ, ack, no redirect:
  - push {`imemData`, `imemAddr`} and set `fetchPC += 4`.
  - stay in REQ with a new `imemAddr` if `count_next < DEPTH`; otherwise go to IDLE.
- REQ, redirect, no ack: go to SQUASH. Load `fetchPC ← redirectPC` and flush the FIFO. Requests cannot be aborted, so `imemReq`/`imemAddr` hold.
- REQ, redirect and ack in the same cycle: discard the data, flush, load `fetchPC ← redirectPC`, and go to REQ with `imemAddr = redirectPC`.
- SQUASH, ack: discard the data and go to REQ at `fetchPC`.
- SQUASH, another redirect: reload `fetchPC` and stay in SQUASH.
- IDLE, redirect: flush, load `fetchPC ← redirectPC`, and go to REQ.
- Pop occurs when `instrTake & instrValid`. `instrTake` while empty is ignored.
- Redirect beats `instrTake` in the same cycle: the FIFO becomes empty.
- Push and pop in the same cycle leave `count` unchanged. This is legal when full, but a full FIFO never has a request outstanding.
- PC arithmetic is modulo 2^AW. Wrap-around from 0xFFFFFFFC to 0 is silent.
- Reset values:
  - state IDLE, `fetchPC = startPC`, `imemAddr = 0`, FIFO empty.
  - all outputs 0.
- Reset mid-request forces IDLE immediately. A late ack arriving after reset is ignored because the block is in IDLE.

## Timing
- Ack at falling edge N → entry visible on `instr`/`instrValid` after edge N. Decode samples it at edge N+1.
- Zero-wait memory sustains 1 instruction per cycle.
- Memory with k wait cycles gives 1 instruction per k+1 cycles.
- First request: `imemReq` rises one cycle after `Reset` falls.
- Redirect → `imemReq` with the new address:
  - next cycle if idle or acked in the same cycle.
  - otherwise one cycle after the pending ack.
- Redirect → first new `instrValid`: at least 2 cycles.
- Head outputs are registered FIFO reads with no combinational path from `imemData`.

## Structure
- Shared package `fetch_pkg`:
  - state enum (IDLE, REQ, SQUASH)
  - `NOP_INSTR = 32'h0`
  - `PC_INC = 4`
- Sub-module `instr_fifo` holds synchronous {instr, pc} storage with push, pop, flush and count. It has no bypass path.
- The top level holds the FSM, `fetchPC` and `imemAddr`.

## Test plan
- Reset with `startPC` = 0x00400000 and zero-wait memory → `imemAddr` = 0x00400000, 0x00400004, …. With `instrTake` = 1, one `instrValid` per cycle carrying the matching PC.
- `instrTake` = 0 with zero-wait memory → exactly `DEPTH` (4) acks, then `imemReq` = 0 and `count` = 4. One take → one new request at the next sequential PC.
- 3-wait memory with redirect to 0x00400100 while a request is outstanding → `imemAddr` stays constant until ack, that data is never pushed, and the next request is to 0x00400100.
- Redirect with ack and `instrTake` in the same cycle → FIFO empty and `count` = 0. `imemAddr` = `redirectPC` next cycle.
- `startPC` = 0xFFFFFFF8 → fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. `instrPCPlus4` of the last is 0x00000004.
- `Reset` asserted for one cycle during an outstanding request, with the ack arriving during reset → outputs 0 and FIFO empty. The next request is to the new `startPC`.
